piso_serial_tx: RTL and testbench

Parallel-in, serial-out transmitter. It accepts one BITS-wide word through a valid/ready handshake and shifts it out one bit per clock, LSB first. While the bits are on the line it asserts a frame-valid strobe, and it pulses done when the frame completes. It is the transmit end of the team's serial shift-register link: its sout/sout_valid pair drives a serial-in register stage that shifts toward the LSB.

---
 rtl/piso_serial_tx.sv | 141 ++++++++++++++
 tb/tb_piso_serial_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in, serial-out transmitter.
//
// Accepts one BITS-wide word through a valid/ready handshake and shifts it out
// LSB first, one bit per clock. sout_valid marks every cycle that carries a
// frame bit; done pulses for one cycle (the first IDLE cycle) after the frame.
//
// Optional build macro: PISO_TX_PARITY_EN
//   When defined, an even-parity bit (XOR of the accepted word) is appended
//   after the data bits, making the frame BITS+1 bits long.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous, active-high reset
//   din_valid  - producer has a word on din
//   din        - parallel word, sampled only on the accept edge
//   din_ready  - high exactly when the FSM is idle
//   sout       - serial data bit (registered)
//   sout_valid - high on every cycle sout carries a frame bit (registered)
//   done       - one-cycle pulse after the last frame bit (registered)

module piso_serial_tx #(
    parameter int unsigned BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            din_valid,
    input  logic [BITS-1:0] din,
    output logic            din_ready,
    output logic            sout,
    output logic            sout_valid,
    output logic            done
);

    localparam int unsigned CntW = $clog2(BITS + 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e            state_q, state_d;
    logic [BITS-1:0]   shreg_q, shreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sout_q, sout_d;
    logic              sout_valid_q, sout_valid_d;
    logic              done_q, done_d;
`ifdef PISO_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        done_d       = 1'b0;
`ifdef PISO_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (din_valid) begin
                    // Bit 0 goes straight to the line; the rest wait in shreg.
                    sout_d       = din[0];
                    shreg_d      = din >> 1;
                    cnt_d        = CntW'(1);
                    sout_valid_d = 1'b1;
                    state_d      = StShift;
`ifdef PISO_TX_PARITY_EN
                    parity_d     = ^din;
`endif
                end else begin
                    sout_d       = 1'b0;
                    sout_valid_d = 1'b0;
                end
            end
            StShift: begin
                if (cnt_q == CntW'(BITS)) begin
                    cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
                    sout_d  = parity_q;
                    state_d = StParity;
`else
                    sout_d       = 1'b0;
                    sout_valid_d = 1'b0;
                    done_d       = 1'b1;
                    state_d      = StIdle;
`endif
                end else begin
                    sout_d  = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
`ifdef PISO_TX_PARITY_EN
            StParity: begin
                sout_d       = 1'b0;
                sout_valid_d = 1'b0;
                done_d       = 1'b1;
                state_d      = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
`ifdef PISO_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Decoded directly from the state flop, so it follows reset immediately.
    assign din_ready  = (state_q == StIdle);
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx with BITS = 4. Expected serial sequences
// are written in line order (first transmitted bit is the leftmost digit).

module tb_piso_serial_tx;

    localparam int unsigned BITS = 4;

    logic            clk;
    logic            reset;
    logic            din_valid;
    logic [BITS-1:0] din;
    logic            din_ready;
    logic            sout;
    logic            sout_valid;
    logic            done;

    int n_checks;
    int n_fails;

    piso_serial_tx #(
        .BITS(BITS)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .sout      (sout),
        .sout_valid(sout_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first cycle after an accept edge. seq is in line order:
    // seq[3] is the first bit on sout. par is the expected parity bit when the
    // parity build is active. Returns positioned in the done cycle.
    task automatic check_frame(input string tag, input logic [3:0] seq, input logic par);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_sout%0d", tag, i), {31'd0, sout}, {31'd0, seq[3-i]});
            check_eq($sformatf("%s_valid%0d", tag, i), {31'd0, sout_valid}, 32'd1);
            check_eq($sformatf("%s_ready%0d", tag, i), {31'd0, din_ready}, 32'd0);
            check_eq($sformatf("%s_done%0d", tag, i), {31'd0, done}, 32'd0);
            tick();
        end
`ifdef PISO_TX_PARITY_EN
        check_eq($sformatf("%s_par", tag), {31'd0, sout}, {31'd0, par});
        check_eq($sformatf("%s_par_valid", tag), {31'd0, sout_valid}, 32'd1);
        check_eq($sformatf("%s_par_ready", tag), {31'd0, din_ready}, 32'd0);
        tick();
`else
        if (par === 1'bx) $display("unexpected unknown parity argument in %s", tag);
`endif
        check_eq($sformatf("%s_done", tag), {31'd0, done}, 32'd1);
        check_eq($sformatf("%s_done_ready", tag), {31'd0, din_ready}, 32'd1);
        check_eq($sformatf("%s_done_valid", tag), {31'd0, sout_valid}, 32'd0);
        check_eq($sformatf("%s_done_sout", tag), {31'd0, sout}, 32'd0);
    endtask

    task automatic accept(input logic [3:0] word);
        din       = word;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        reset     = 1'b0;
        din_valid = 1'b0;
        din       = '0;

        // 1. Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1;
        check_eq("rst_sout", {31'd0, sout}, 32'd0);
        check_eq("rst_valid", {31'd0, sout_valid}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_ready", {31'd0, din_ready}, 32'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_eq("idle_ready", {31'd0, din_ready}, 32'd1);
        check_eq("idle_valid", {31'd0, sout_valid}, 32'd0);

        // 2. Single frame 4'b1011 -> line order 1,1,0,1; parity 1.
        accept(4'b1011);
        check_frame("single", 4'b1101, 1'b1);
        tick();
        check_eq("single_done_once", {31'd0, done}, 32'd0);

        // 3. Back-to-back: A (0,1,0,1) then 5 (1,0,1,0), valid held high.
        din       = 4'hA;
        din_valid = 1'b1;
        tick();
        check_frame("b2b_a", 4'b0101, 1'b0);
        din = 4'h5;
        tick();
        check_frame("b2b_5", 4'b1010, 1'b0);
        din_valid = 1'b0;
        tick();
        check_eq("b2b_done_once", {31'd0, done}, 32'd0);
        check_eq("b2b_idle_valid", {31'd0, sout_valid}, 32'd0);

        // 4. Busy ignore: C (0,0,1,1); 3 held during shifting, taken at done.
        accept(4'hC);
        din       = 4'h3;
        din_valid = 1'b1;
        check_frame("busy_c", 4'b0011, 1'b0);
        tick();
        din_valid = 1'b0;
        check_frame("busy_3", 4'b1100, 1'b0);
        tick();

        // 5. Reset mid-frame: F aborted after two bits, no done pulse.
        accept(4'hF);
        check_eq("abort_b0", {31'd0, sout}, 32'd1);
        tick();
        check_eq("abort_b1", {31'd0, sout}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("abort_sout", {31'd0, sout}, 32'd0);
        check_eq("abort_valid", {31'd0, sout_valid}, 32'd0);
        check_eq("abort_ready", {31'd0, din_ready}, 32'd1);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("abort_nodone%0d", i), {31'd0, done}, 32'd0);
            tick();
        end
        accept(4'h6);
        check_frame("after_abort", 4'b0110, 1'b0);
        tick();

        // 6. Parity-oriented words: 0111 -> 1,1,1,0 p=1; 0011 -> 1,1,0,0 p=0.
        accept(4'b0111);
        check_frame("par_7", 4'b1110, 1'b1);
        tick();
        accept(4'b0011);
        check_frame("par_3", 4'b1100, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
